// File: rtl/rom_arbiter.sv
// Shares one rom_wrapper between requesters A and B; responses arrive ROM_LATENCY+1 cycles after the handshake.
// One grant per cycle, no response backpressure; defining ROM_ARB_FIXED_PRIO_EN makes A always win contention.
module rom_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int ROM_LATENCY = 2   // legal 1..4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic                  a_ready,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ready,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  busy
);

  logic                   grant_a, grant_b;
  logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ROM_LATENCY-1:0] tag_own_q, tag_own_d;   // owner bit: 1 = B
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic                   a_rsp_valid_q, a_rsp_valid_d;
  logic                   b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_WIDTH-1:0]  a_rsp_data_q, a_rsp_data_d;
  logic [DATA_WIDTH-1:0]  b_rsp_data_q, b_rsp_data_d;
  logic                   busy_q, busy_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic                   last_grant_q, last_grant_d;   // 1 = B won the last handshake
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && enable) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      if (a_valid)      grant_a = 1'b1;
      else if (b_valid) grant_b = 1'b1;
`else
      if (a_valid && b_valid) begin
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
`endif
    end
  end

`ifndef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a)      last_grant_d = 1'b0;
    else if (grant_b) last_grant_d = 1'b1;
  end
`endif

  // Idle cycles keep the last issued address on the ROM bus to avoid toggling.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (grant_a)      rom_addr_d = a_addr;
    else if (grant_b) rom_addr_d = b_addr;
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = grant_a | grant_b;
    tag_own_d[0] = grant_b;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
    a_rsp_valid_d = tag_vld_q[ROM_LATENCY-1] && !tag_own_q[ROM_LATENCY-1];
    b_rsp_valid_d = tag_vld_q[ROM_LATENCY-1] &&  tag_own_q[ROM_LATENCY-1];
    a_rsp_data_d  = a_rsp_valid_d ? rom_dout : a_rsp_data_q;
    b_rsp_data_d  = b_rsp_valid_d ? rom_dout : b_rsp_data_q;
    busy_d        = |tag_vld_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q     <= '0;
      tag_own_q     <= '0;
      rom_addr_q    <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
      busy_q        <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      tag_vld_q     <= tag_vld_d;
      tag_own_q     <= tag_own_d;
      rom_addr_q    <= rom_addr_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
      busy_q        <= busy_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant_q  <= last_grant_d;
`endif
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign rom_cs      = grant_a | grant_b;
  assign rom_addr    = rom_addr_d;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = a_rsp_data_q;
  assign b_rsp_data  = b_rsp_data_q;
  assign busy        = busy_q;

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one rom_wrapper instance (8x1024 ROM) between two read requesters, A and B.
- Arbitrates with a round-robin policy and issues at most one read per cycle to the ROM.
- Tracks in-flight reads in a tag pipeline and returns each read's data to the requester that issued it.
- Sits between on-chip requesters (e.g. the test controller and the scan/LA interface) and rom_wrapper.

Parameters:
- DATA_WIDTH, 8, ROM data width.
- ADDR_WIDTH, 10, ROM address width.
- ROM_LATENCY, 2, cycles from rom_cs/rom_addr driven (handshake cycle) until rom_dout is valid; legal range 1..4.

Ports:
- clk  input  1  clock; also drives rom_wrapper.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new grants; in-flight reads complete.
- a_valid  input  1  requester A read request.
- a_addr  input  ADDR_WIDTH  requester A address.
- a_ready  output  1  A request accepted this cycle.
- a_rsp_valid  output  1  one-cycle pulse, a_rsp_data valid.
- a_rsp_data  output  DATA_WIDTH  read data for A.
- b_valid, b_addr, b_ready, b_rsp_valid, b_rsp_data: as A, for requester B.
- rom_cs  output  1  to rom_wrapper cs (rom_wrapper registers it).
- rom_addr  output  ADDR_WIDTH  to rom_wrapper addr.
- rom_dout  input  DATA_WIDTH  from rom_wrapper dout.
- busy  output  1  high while any read is in flight.

Behaviour:
- Reset: all synchronous on clk with reset high.
  - Outputs go to zero: a_ready, b_ready, rsp valids, rsp data, busy, rom_cs, rom_addr.
  - Tag pipeline is cleared.
  - last_grant is set to B, so A wins the first contention.
- Grant logic: combinational from a_valid, b_valid, enable, last_grant; reset forces no grant.
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester other than last_grant.
  - enable low -> no grant.
- Handshake: a transfer occurs in a cycle where x_valid && x_ready.
  - At most one of a_ready/b_ready is high per cycle.
  - x_ready may depend on x_valid; requesters must hold addr stable while valid and not accepted.
  - No backpressure limit: one read can be issued every cycle.
- ROM drive: in the handshake cycle, rom_cs=1 and rom_addr=the granted address (combinational).
  - Otherwise rom_cs=0 and rom_addr holds its last issued value (registered hold, avoids toggling).
- last_grant updates at the clock edge of every handshake.
- Tag pipeline: ROM_LATENCY stages of {valid, owner}.
  - Stage 0 is loaded at the handshake edge; stages shift every cycle.
  - When the final stage is valid, rom_dout is sampled into the owner's rsp_data register and the owner's rsp_valid pulses for exactly one cycle.
  - Response latency is ROM_LATENCY+1 cycles after the handshake cycle (default 3): handshake in cycle k -> x_rsp_valid in cycle k+3.
- Responses:
  - Each requester receives its responses in issue order; there is no response backpressure.
  - rsp_data holds its last value between pulses.
  - The non-owner's rsp_valid stays 0.
- busy = OR of all tag pipeline valid bits, registered.
- Back-to-back: alternating grants under continuous contention produce A,B,A,B; responses arrive on consecutive cycles in the same order.
- Reset mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them. rom_wrapper output during this window is ignored.
- enable deasserted mid-burst: no new handshakes; in-flight responses still delivered; busy falls after the last response.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins contention; B is granted only when a_valid is low. last_grant is not implemented.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset then A only: a_valid=1, a_addr=0x005 for 1 cycle at cycle k -> a_ready=1 at k, rom_cs=1 and rom_addr=0x005 at k, a_rsp_valid pulse at k+3 with a_rsp_data=ROM[0x005], b_rsp_valid stays 0.
- Contention after reset: a_valid=b_valid=1 (a_addr=0x010, b_addr=0x3FF) held 4 cycles -> grants A,B,A,B; responses A,B,A,B on four consecutive cycles with the correct data. Under ROM_ARB_FIXED_PRIO_EN: grants A,A,A,A and b_ready never high.
- Streaming: A issues addresses 0..15 on consecutive cycles -> 16 consecutive a_rsp_valid pulses with data ROM[0..15]; busy high throughout, low 1 cycle after the last pulse.
- enable low with a_valid=1 for 5 cycles -> a_ready=0 and rom_cs=0 throughout. enable raised -> grant in the same cycle.
- Reset asserted 1 cycle after issuing A reads at 0x020 and 0x021 -> no a_rsp_valid afterwards, busy=0 and rom_cs=0 during reset. After release, the first contention grants A.
- Boundary address: B reads 0x3FF then 0x000 -> b_rsp_data=ROM[0x3FF] then ROM[0x000]; a_rsp_data unchanged.
